// File: rtl/pipe_pkg.sv
// Shared pipeline types for the memory stage: FSM states,
// EX/MEM and MEM/WB bundles, and a writeback builder.
package pipe_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic [31:0] rd;
        logic [31:0] a;
        logic [31:0] st_data;
        logic [31:0] pc4;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        reg_write;
        logic [4:0]  rd_add;
    } ex_mem_t;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic [4:0]  rd_add;
        logic [31:0] data;
        logic [31:0] pc4;
    } mem_wb_t;

    // x0 is hardwired, so a write to it never reaches the register file
    function automatic mem_wb_t make_wb(
        input logic        we,
        input logic [4:0]  rd_add,
        input logic [31:0] data,
        input logic [31:0] pc4
    );
        mem_wb_t w;
        w.valid     = 1'b1;
        w.reg_write = we && (rd_add != 5'd0);
        w.rd_add    = rd_add;
        w.data      = data;
        w.pc4       = pc4;
        return w;
    endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Wait-cycle counter for outstanding data-memory accesses;
// tc flags the last permitted cycle before abort.
module mem_timeout_ctr #(
    parameter int LIMIT = 16,
    localparam int CW = $clog2(LIMIT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          load,
    input  logic          inc,
    input  logic [CW-1:0] load_val,
    output logic          tc
);

    logic [CW-1:0] count;

    assign tc = (count == CW'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (inc && !tc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: LDW/STW over a req/ack port
// with timeout, ALU pass-through, registered writeback.
module mem_stage
    import pipe_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_2_mem,
    input  logic [31:0]       rd_2_mem,
    input  logic [31:0]       A_2_mem,
    input  logic [31:0]       st_data_2_mem,
    input  logic [31:0]       pc4_2_mem,
    input  logic              mem_read_2_mem,
    input  logic              mem_write_2_mem,
    input  logic              mem_to_reg_2_mem,
    input  logic              reg_write_2_mem,
    input  logic [4:0]        rd_add_value_2_mem,
    output logic              stall_2_ex,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_ack,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [4:0]        wb_rd_add,
    output logic [31:0]       wb_data,
    output logic [31:0]       wb_pc4,
    output logic              mem_err
);

    mem_state_e  state;
    ex_mem_t     in;
    mem_wb_t     wb;

    logic        is_mem;
    logic        aligned;
    logic        issue;
    logic        tc;
    logic        timeout;
    logic        leave;

    logic [31:0] cap_rd;
    logic [31:0] cap_pc4;
    logic        cap_m2r;
    logic        cap_rw;
    logic [4:0]  cap_rd_add;

    assign in = '{
        rd:         rd_2_mem,
        a:          A_2_mem,
        st_data:    st_data_2_mem,
        pc4:        pc4_2_mem,
        mem_read:   mem_read_2_mem,
        mem_write:  mem_write_2_mem,
        mem_to_reg: mem_to_reg_2_mem,
        reg_write:  reg_write_2_mem,
        rd_add:     rd_add_value_2_mem
    };

    assign is_mem  = in.mem_read | in.mem_write;
    assign aligned = (in.a[1:0] == 2'b00);
    assign issue   = (state == IDLE) & valid_2_mem & is_mem & aligned;
    assign timeout = (state == WAIT) & tc & ~dmem_ack;
    assign leave   = (state == WAIT) & (dmem_ack | tc);

    // Release upstream on the cycle the access resolves (ack or abort)
    assign stall_2_ex = reset &
        (issue | ((state == WAIT) & ~dmem_ack & ~tc));

    mem_timeout_ctr #(
        .LIMIT    (TIMEOUT_CYCLES)
    ) u_ctr (
        .clk      (clk),
        .reset    (reset),
        .clear    (leave),
        .load     (issue),
        .inc      (state == WAIT),
        .load_val ('0),
        .tc       (tc)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            wb         <= '0;
            mem_err    <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            cap_rd     <= '0;
            cap_pc4    <= '0;
            cap_m2r    <= 1'b0;
            cap_rw     <= 1'b0;
            cap_rd_add <= '0;
        end else begin
            wb.valid <= 1'b0;
            mem_err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (valid_2_mem) begin
                        if (!is_mem) begin
                            wb <= make_wb(in.reg_write, in.rd_add,
                                          in.rd, in.pc4);
                        end else if (!aligned) begin
                            wb      <= make_wb(1'b0, in.rd_add,
                                               in.rd, in.pc4);
                            mem_err <= 1'b1;
                        end else begin
                            state      <= WAIT;
                            dmem_req   <= 1'b1;
                            dmem_we    <= in.mem_write;
                            dmem_addr  <= ADDR_W'(in.a);
                            dmem_wdata <= in.st_data;
                            cap_rd     <= in.rd;
                            cap_pc4    <= in.pc4;
                            cap_m2r    <= in.mem_to_reg;
                            cap_rw     <= in.reg_write;
                            cap_rd_add <= in.rd_add;
                        end
                    end
                end
                WAIT: begin
                    if (dmem_ack) begin
                        state    <= IDLE;
                        dmem_req <= 1'b0;
                        wb <= make_wb(cap_rw & ~dmem_we, cap_rd_add,
                                      (~dmem_we & cap_m2r) ?
                                      dmem_rdata : cap_rd,
                                      cap_pc4);
                    end else if (timeout) begin
                        state    <= IDLE;
                        dmem_req <= 1'b0;
                        wb       <= make_wb(1'b0, cap_rd_add,
                                            cap_rd, cap_pc4);
                        mem_err  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign wb_valid     = wb.valid;
    assign wb_reg_write = wb.reg_write;
    assign wb_rd_add    = wb.rd_add;
    assign wb_data      = wb.data;
    assign wb_pc4       = wb.pc4;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage; consumes the EX/MEM register outputs (ALU result, effective address, next-PC, memory control, destination register address).
- Performs LDW/STW through a request/acknowledge data-memory port with variable latency, stalls upstream while an access is outstanding, and presents registered results to writeback.
- Non-memory instructions pass through with fixed 1-cycle latency.

Parameters:
TIMEOUT_CYCLES, 16, max cycles waiting for dmem_ack before the access is aborted (>=1)
ADDR_W, 32, width of dmem_addr (byte address)

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-low
valid_2_mem  input  1  EX/MEM slot holds a live instruction
rd_2_mem  input  32  ALU result (arith/logic ops)
A_2_mem  input  32  effective byte address (LDW/STW)
st_data_2_mem  input  32  store data (rt value)
pc4_2_mem  input  32  next-PC from EX
mem_read_2_mem  input  1  load
mem_write_2_mem  input  1  store
mem_to_reg_2_mem  input  1  writeback selects load data
reg_write_2_mem  input  1  instruction writes a register
rd_add_value_2_mem  input  5  destination register address
stall_2_ex  output  1  hold EX/MEM register and earlier stages
dmem_req  output  1  memory request, held until ack
dmem_we  output  1  1=write, 0=read; valid with dmem_req
dmem_addr  output  ADDR_W  byte address
dmem_wdata  output  32  store data
dmem_rdata  input  32  load data, valid with dmem_ack
dmem_ack  input  1  access complete
wb_valid  output  1  writeback slot valid
wb_reg_write  output  1  write register file
wb_rd_add  output  5  destination register address
wb_data  output  32  writeback data
wb_pc4  output  32  next-PC forwarded
mem_err  output  1  one-cycle pulse: misaligned or timed-out access

Behaviour:
- Reset (reset==0 at posedge): state IDLE; all outputs 0, timeout counter 0. Reset mid-access drops dmem_req in the next cycle; the access is discarded and no writeback is produced.
- FSM states: IDLE, WAIT.
- IDLE, valid_2_mem=0: wb_valid<=0.
- IDLE, valid and neither mem_read nor mem_write: next cycle wb_valid=1, wb_data=rd_2_mem, wb_reg_write=reg_write_2_mem, wb_rd_add, wb_pc4 registered. Latency 1; no stall.
- IDLE, valid memory op with A_2_mem[1:0]!=0: no request issued; next cycle wb_valid=1, wb_reg_write=0, mem_err pulse.
- IDLE, valid aligned memory op: stall_2_ex=1 combinationally in the same cycle. Capture address, data, dest, and controls. Next cycle dmem_req=1, dmem_we=mem_write_2_mem; go to WAIT; wb_valid<=0.
- WAIT: dmem_req, dmem_we, dmem_addr, and dmem_wdata stay stable until ack. stall_2_ex=1. The counter increments each cycle.
- WAIT, dmem_ack=1: dmem_req<=0; return to IDLE; next cycle wb_valid=1.
  - Load: wb_data = dmem_rdata when mem_to_reg, else captured ALU result; wb_reg_write = captured reg_write.
  - Store: wb_reg_write=0.
- stall_2_ex deasserts in the ack cycle, so upstream advances exactly once per completed access.
- WAIT timeout: counter reaches TIMEOUT_CYCLES-1 without ack → abort; dmem_req<=0; return to IDLE; wb_valid=1, wb_reg_write=0, mem_err pulse. A late ack arriving in IDLE is ignored.
- Ack in the same cycle as the final timeout count: ack wins.
- mem_read and mem_write both set: treated as store (write precedence).
- wb_reg_write is forced 0 when wb_rd_add==0.
- stall_2_ex is the only combinational output; all others are registered.

Decomposition:
- Shared package (pipe_pkg): mem_state_e {IDLE, WAIT}; ex_mem_t struct (rd, A, st_data, pc4, controls, rd_add); mem_wb_t struct (valid, reg_write, rd_add, data, pc4).
- One sub-module: mem_timeout_ctr (load/clear/increment, terminal-count flag).

Test Plan:
1. ALU pass-through: valid, rd_2_mem=0x0000_0005, reg_write=1, rd_add=3 → next cycle wb_valid=1, wb_data=5, wb_rd_add=3, wb_reg_write=1; stall_2_ex never high.
2. Load, 3-cycle ack latency: A=0x100, dmem_rdata=0xDEAD_BEEF, mem_to_reg=1, rd_add=7 → dmem_req high with dmem_addr=0x100 and we=0 until ack; stall_2_ex high 4 cycles; wb_data=0xDEADBEEF, wb_reg_write=1.
3. Store, 0-wait ack: A=0x40, st_data=0x1234 → one request cycle with we=1, wdata=0x1234; wb_valid=1, wb_reg_write=0.
4. Misaligned: A=0x102, mem_read=1 → dmem_req stays 0; mem_err pulses one cycle; wb_reg_write=0.
5. Timeout, TIMEOUT_CYCLES=4, no ack → dmem_req drops after 4 cycles; mem_err pulse; a later ack is ignored.
6. Reset asserted in WAIT → next cycle dmem_req=0, wb_valid=0, stall_2_ex=0; a new load after reset completes normally.
